bru_redirect_ctrl: RTL and testbench

- Sequences the branch resolution unit's result into the front end of the core.
- Samples the BRU decision (is_taken, pc_bru) from EX and issues a held PC redirect to fetch with a valid/ready handshake.
- Flushes wrong-path IF/ID and ID/EX contents and stalls EX while a redirect is outstanding.
- Flags misaligned targets and keeps saturating branch/taken performance counters.

---
 rtl/core_pkg.sv | 12 +
 rtl/sat_counter.sv | 16 +
 rtl/bru_redirect_ctrl.sv | 67 ++++++
 tb/tb_bru_redirect_ctrl.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared types and encodings for the branch redirect controller.
package core_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] CTRL_PCREL = 2'b00;
  localparam logic [1:0] CTRL_JALR  = 2'b11;
  typedef enum logic {IDLE, REDIRECT} state_e;
  typedef enum logic {CLS_PCREL, CLS_JALR} ctrl_class_e;
  // Encodings 01/10 are not produced by decode; fold them into PC-relative.
  function automatic ctrl_class_e ctrl_class(input logic [1:0] c);
    return (c == CTRL_JALR) ? CLS_JALR : CLS_PCREL;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/bru_redirect_ctrl.sv
// bru_redirect_ctrl: turns a resolved BRU decision into a held fetch redirect with flushes.
module bru_redirect_ctrl
  import core_pkg::*;
#(
  parameter int XLEN       = core_pkg::XLEN,
  parameter int CNT_W      = 16,
  parameter int ALIGN_BITS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_ctrl,
  input  logic [1:0]       ex_is_control,
  input  logic             ex_stall,
  input  logic             bru_is_taken,
  input  logic [XLEN-1:0]  bru_pc,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             ex_hold,
  output logic             misalign_exc,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] ctrl_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  state_e            state_q, state_d;
  logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d, misalign_addr_q, misalign_addr_d;
  logic              misalign_exc_q, misalign_exc_d;
  logic              resolve, aligned, take_ok, take_bad, ctrl_inc;
  ctrl_class_e       cls;
  assign resolve  = ex_valid & ex_ctrl & ~ex_stall & (state_q == IDLE);
  assign aligned  = bru_pc[ALIGN_BITS-1:0] == '0;
  assign take_ok  = resolve & bru_is_taken & aligned;
  assign take_bad = resolve & bru_is_taken & ~aligned;
  assign cls      = ctrl_class(ex_is_control);
  assign ctrl_inc = resolve & (cls == CLS_PCREL || cls == CLS_JALR);
  always_comb begin
    state_d         = (state_q == REDIRECT) ? (fetch_ready ? IDLE : REDIRECT)
                                            : (take_ok ? REDIRECT : IDLE);
    redirect_pc_d   = take_ok ? bru_pc : redirect_pc_q;
    misalign_exc_d  = take_bad;
    misalign_addr_d = take_bad ? bru_pc : misalign_addr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q         <= IDLE;
      redirect_pc_q   <= '0;
      misalign_exc_q  <= 1'b0;
      misalign_addr_q <= '0;
    end else begin
      state_q         <= state_d;
      redirect_pc_q   <= redirect_pc_d;
      misalign_exc_q  <= misalign_exc_d;
      misalign_addr_q <= misalign_addr_d;
    end
  assign redirect_valid = state_q == REDIRECT;
  assign flush_if_id    = redirect_valid;
  assign flush_id_ex    = redirect_valid;
  assign ex_hold        = redirect_valid;
  assign redirect_pc    = redirect_pc_q;
  assign misalign_exc   = misalign_exc_q;
  assign misalign_addr  = misalign_addr_q;
  sat_counter #(.CNT_W(CNT_W)) u_ctrl_cnt (.clk(clk), .rst_n(rst_n), .inc(ctrl_inc), .cnt(ctrl_cnt));
  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (.clk(clk), .rst_n(rst_n), .inc(resolve & bru_is_taken), .cnt(taken_cnt));
endmodule

// File: tb/tb_bru_redirect_ctrl.sv
// tb_bru_redirect_ctrl: directed and random stimulus against a transaction-level model.
module tb_bru_redirect_ctrl;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic clk = 0, rst_n = 0;
  logic ex_valid, ex_ctrl, ex_stall, bru_is_taken, fetch_ready;
  logic [1:0] ex_is_control;
  logic [31:0] bru_pc;
  logic redirect_valid, flush_if_id, flush_id_ex, ex_hold, misalign_exc;
  logic [31:0] redirect_pc, misalign_addr;
  logic [CNT_W-1:0] ctrl_cnt, taken_cnt;
  int n_chk = 0, n_pass = 0;
  bit m_pend, m_exc;
  logic [31:0] m_pc, m_addr;
  int m_ctrl, m_taken;
  always #5 clk = ~clk;
  bru_redirect_ctrl #(.XLEN(32), .CNT_W(CNT_W), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_is_control(ex_is_control), .ex_stall(ex_stall), .bru_is_taken(bru_is_taken),
    .bru_pc(bru_pc), .fetch_ready(fetch_ready), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .ex_hold(ex_hold), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
    .ctrl_cnt(ctrl_cnt), .taken_cnt(taken_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic drive(input bit v, input bit c, input bit [1:0] cls, input bit st,
                       input bit tk, input logic [31:0] pc, input bit fr);
    ex_valid = v; ex_ctrl = c; ex_is_control = cls; ex_stall = st;
    bru_is_taken = tk; bru_pc = pc; fetch_ready = fr;
  endtask
  task automatic model_reset();
    m_pend = 0; m_exc = 0; m_pc = 0; m_addr = 0; m_ctrl = 0; m_taken = 0;
  endtask
  task automatic check_all();
    chk("redirect_valid", redirect_valid, m_pend);
    chk("flush_if_id", flush_if_id, m_pend);
    chk("flush_id_ex", flush_id_ex, m_pend);
    chk("ex_hold", ex_hold, m_pend);
    chk("redirect_pc", redirect_pc, m_pc);
    chk("misalign_exc", misalign_exc, m_exc);
    chk("misalign_addr", misalign_addr, m_addr);
    chk("ctrl_cnt", ctrl_cnt, m_ctrl);
    chk("taken_cnt", taken_cnt, m_taken);
  endtask
  // One clock: predict from the pre-edge inputs, then compare just after the edge.
  task automatic tick();
    m_exc = 0;
    if (m_pend) begin
      if (fetch_ready) m_pend = 0;
    end else if (ex_valid && ex_ctrl && !ex_stall) begin
      m_ctrl = (m_ctrl < CMAX) ? m_ctrl + 1 : CMAX;
      if (bru_is_taken) begin
        m_taken = (m_taken < CMAX) ? m_taken + 1 : CMAX;
        if (bru_pc % 4 == 0) begin m_pend = 1; m_pc = bru_pc; end
        else begin m_exc = 1; m_addr = bru_pc; end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask
  task automatic idle();
    drive(0, 0, 2'b00, 0, 0, 32'h0, 1);
  endtask
  initial begin
    idle();
    model_reset();
    #12;
    check_all();
    rst_n = 1;
    // taken branch, fetch ready immediately
    drive(1, 1, 2'b00, 0, 1, 32'h12345678, 1);
    tick();
    chk("tb_rpc", redirect_pc, 32'h12345678);
    chk("tb_rv", redirect_valid, 1);
    idle();
    tick();
    chk("tb_rv_drop", redirect_valid, 0);
    // backpressure: five cycles of fetch_ready=0
    drive(1, 1, 2'b00, 0, 1, 32'h0000_4000, 0);
    tick();
    idle(); fetch_ready = 0;
    for (int i = 0; i < 4; i++) tick();
    chk("bp_hold", ex_hold, 1);
    fetch_ready = 1;
    tick();
    idle();
    tick();
    // not taken and stalled resolves
    drive(1, 1, 2'b00, 0, 0, 32'h0000_8000, 1);
    tick();
    drive(1, 1, 2'b00, 1, 1, 32'h0000_9000, 1);
    tick();
    // misaligned JALR
    drive(1, 1, 2'b11, 0, 1, 32'h12348AC6, 1);
    tick();
    chk("mis_addr", misalign_addr, 32'h12348AC6);
    idle();
    tick();
    chk("mis_pulse_end", misalign_exc, 0);
    // async reset while a redirect is stuck
    drive(1, 1, 2'b00, 0, 1, 32'h0000_A000, 0);
    tick();
    idle(); fetch_ready = 0;
    tick();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("async_rv", redirect_valid, 0);
    check_all();
    @(posedge clk);
    #2 rst_n = 1;
    check_all();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = $urandom;
      if ($urandom_range(1, 0) != 0) pc[1:0] = 2'b00;
      drive($urandom_range(9, 0) < 8, $urandom_range(9, 0) < 7, 2'($urandom),
            $urandom_range(9, 0) < 2, $urandom_range(1, 0) != 0, pc,
            $urandom_range(9, 0) < 6);
      tick();
    end
    // saturation: 17 taken resolves from a clean reset
    @(negedge clk) rst_n = 0;
    model_reset();
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 2'b00, 0, 1, 32'h0000_1000 + 32'(i * 4), 1);
      tick();
      tick();
    end
    chk("sat_ctrl", ctrl_cnt, 4'hF);
    chk("sat_taken", taken_cnt, 4'hF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
